// File: rtl/bless_age_allocator.sv
// Age-ranked BLESS output-port allocator for the 5-port bufferless router; drives route_config.
// Optional macro BLESS_RR_TIE_EN: equal ages resolve by a rotating pointer instead of lowest index.
module bless_age_allocator #(
    parameter logic [2:0]  MY_X  = 3'd2,
    parameter logic [2:0]  MY_Y  = 3'd2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [12:0]      control0_in,
    input  logic [12:0]      control1_in,
    input  logic [12:0]      control2_in,
    input  logic [12:0]      control3_in,
    input  logic [12:0]      control4_in,
    input  logic             count_clear,
    output logic [14:0]      route_config,
    output logic             inject_grant,
    output logic             eject_valid,
    output logic [CNT_W-1:0] deflect_count
);

    localparam int unsigned NPORT = 5;
    localparam int unsigned NNET  = 4;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [2:0] P_N    = 3'd0;
    localparam logic [2:0] P_E    = 3'd1;
    localparam logic [2:0] P_S    = 3'd2;
    localparam logic [2:0] P_W    = 3'd3;
    localparam logic [2:0] P_L    = 3'd4;
    localparam logic [2:0] P_NONE = 3'd7;

    logic [12:0]      w_ctrl    [NPORT];
    logic [NPORT-1:0] w_valid;
    logic [NPORT-1:0] w_arrived;
    logic [NPORT-1:0] w_has_sec;
    logic [2:0]       w_pref    [NPORT];
    logic [2:0]       w_sec     [NPORT];
    logic [5:0]       w_age     [NNET];
    logic [2:0]       w_prio    [NNET];
    logic [2:0]       w_rank    [NNET];
    logic [2:0]       w_sel     [NPORT];
    logic [7:0]       w_used;
    logic [NPORT-1:0] w_defl;
    logic [2:0]       w_ndefl;
    logic [SUM_W-1:0] w_cnt_sum;

    logic [14:0]      r_route;
    logic             r_inject;
    logic             r_eject;
    logic [CNT_W-1:0] r_defl_cnt;

    assign w_ctrl[0] = control0_in;
    assign w_ctrl[1] = control1_in;
    assign w_ctrl[2] = control2_in;
    assign w_ctrl[3] = control3_in;
    assign w_ctrl[4] = control4_in;

    // Lowest-numbered free network port; P_NONE when 0-3 are all taken.
    function automatic logic [2:0] lowest_free(input logic [7:0] used);
        logic [2:0] p;
        p = P_NONE;
        for (int k = NNET - 1; k >= 0; k--) begin
            if (!used[k]) p = 3'(k);
        end
        return p;
    endfunction

    // Decode each control word into valid/age and productive port choices.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_valid[i]   = w_ctrl[i][12];
            w_arrived[i] = (w_ctrl[i][5:3] == MY_X) && (w_ctrl[i][2:0] == MY_Y);
            w_has_sec[i] = (w_ctrl[i][5:3] != MY_X) && (w_ctrl[i][2:0] != MY_Y);
            if (w_ctrl[i][5:3] != MY_X)
                w_pref[i] = (w_ctrl[i][5:3] > MY_X) ? P_E : P_W;
            else if (w_ctrl[i][2:0] != MY_Y)
                w_pref[i] = (w_ctrl[i][2:0] > MY_Y) ? P_N : P_S;
            else
                w_pref[i] = P_L;
            w_sec[i] = P_NONE;
            if (w_has_sec[i])
                w_sec[i] = (w_ctrl[i][2:0] > MY_Y) ? P_N : P_S;
        end
        for (int i = 0; i < NNET; i++) begin
            w_age[i] = w_ctrl[i][11:6];
        end
    end

`ifdef BLESS_RR_TIE_EN
    logic [2:0] r_rr_ptr;

    // Tie priority is distance from the pointer, modulo 5.
    always_comb begin
        for (int i = 0; i < NNET; i++) begin
            if (3'(i) >= r_rr_ptr)
                w_prio[i] = 3'(i) - r_rr_ptr;
            else
                w_prio[i] = 3'(i) + 3'd5 - r_rr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_rr_ptr <= 3'd0;
        else if (|w_valid)
            r_rr_ptr <= (r_rr_ptr == 3'd4) ? 3'd0 : r_rr_ptr + 3'd1;
    end
`else
    always_comb begin
        for (int i = 0; i < NNET; i++) begin
            w_prio[i] = 3'(i);
        end
    end
`endif

    // Rank of each network flit = number of valid network flits that beat it.
    always_comb begin
        for (int i = 0; i < NNET; i++) begin
            w_rank[i] = 3'd0;
            for (int j = 0; j < NNET; j++) begin
                if ((j != i) && w_valid[j] &&
                    ((w_age[j] > w_age[i]) ||
                     ((w_age[j] == w_age[i]) && (w_prio[j] < w_prio[i]))))
                    w_rank[i] = w_rank[i] + 3'd1;
            end
        end
    end

    // Greedy allocation: network flits in rank order, then the injection flit on leftovers.
    always_comb begin
        w_used = 8'd0;
        w_defl = '0;
        for (int i = 0; i < NPORT; i++) begin
            w_sel[i] = P_NONE;
        end
        for (int pos = 0; pos < NNET; pos++) begin
            for (int i = 0; i < NNET; i++) begin
                if (w_valid[i] && (w_rank[i] == 3'(pos))) begin
                    if (!w_used[w_pref[i]]) begin
                        w_sel[i] = w_pref[i];
                    end else if (w_has_sec[i] && !w_used[w_sec[i]]) begin
                        w_sel[i] = w_sec[i];
                    end else begin
                        w_sel[i]  = lowest_free(w_used);
                        w_defl[i] = 1'b1;
                    end
                    w_used[w_sel[i]] = 1'b1;
                end
            end
        end
        if (w_valid[4]) begin
            if (w_arrived[4]) begin
                if (!w_used[P_L]) w_sel[4] = P_L;
            end else if (!w_used[w_pref[4]]) begin
                w_sel[4] = w_pref[4];
            end else if (w_has_sec[4] && !w_used[w_sec[4]]) begin
                w_sel[4] = w_sec[4];
            end else begin
                w_sel[4]  = lowest_free(w_used);
                w_defl[4] = (w_sel[4] != P_NONE);
            end
            if (w_sel[4] != P_NONE) w_used[w_sel[4]] = 1'b1;
        end
    end

    always_comb begin
        w_ndefl = 3'd0;
        for (int i = 0; i < NPORT; i++) begin
            w_ndefl = w_ndefl + 3'(w_defl[i]);
        end
        w_cnt_sum = {1'b0, r_defl_cnt} + SUM_W'(w_ndefl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_route    <= 15'h7FFF;
            r_inject   <= 1'b0;
            r_eject    <= 1'b0;
            r_defl_cnt <= '0;
        end else begin
            r_route  <= {w_sel[4], w_sel[3], w_sel[2], w_sel[1], w_sel[0]};
            r_inject <= (w_sel[4] != P_NONE);
            r_eject  <= w_used[P_L];
            if (count_clear)
                r_defl_cnt <= '0;
            else if (w_cnt_sum[SUM_W-1])
                r_defl_cnt <= '1;
            else
                r_defl_cnt <= w_cnt_sum[CNT_W-1:0];
        end
    end

    assign route_config  = r_route;
    assign inject_grant  = r_inject;
    assign eject_valid   = r_eject;
    assign deflect_count = r_defl_cnt;

endmodule

// File: tb/tb_bless_age_allocator.sv
// Directed self-checking bench for bless_age_allocator (router at (2,2), 16-bit counter).
module tb_bless_age_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] c0, c1, c2, c3, c4;
    logic        count_clear;
    logic [14:0] route_config;
    logic        inject_grant;
    logic        eject_valid;
    logic [15:0] deflect_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bless_age_allocator #(.MY_X(3'd2), .MY_Y(3'd2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .control0_in  (c0),
        .control1_in  (c1),
        .control2_in  (c2),
        .control3_in  (c3),
        .control4_in  (c4),
        .count_clear  (count_clear),
        .route_config (route_config),
        .inject_grant (inject_grant),
        .eject_valid  (eject_valid),
        .deflect_count(deflect_count)
    );

    task automatic set_in(input logic [12:0] a, input logic [12:0] b, input logic [12:0] c,
                          input logic [12:0] d, input logic [12:0] e);
        c0 = a; c1 = b; c2 = c; c3 = d; c4 = e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; count_clear = 1'b0;
        set_in(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
        step(); step();
        n_vec++; if (route_config !== 15'h7FFF) begin n_miss++; $display("FAIL reset_route got %h want 7fff", route_config); end
        n_vec++; if (inject_grant !== 1'b0) begin n_miss++; $display("FAIL reset_inject got %b want 0", inject_grant); end
        n_vec++; if (eject_valid !== 1'b0) begin n_miss++; $display("FAIL reset_eject got %b want 0", eject_valid); end
        n_vec++; if (deflect_count !== 16'h0000) begin n_miss++; $display("FAIL reset_count got %h want 0000", deflect_count); end
        rst = 1'b0;
    endtask

    task automatic test_single_flit();
        set_in(13'h115A, 13'h0, 13'h0, 13'h0, 13'h0);
        step();
        n_vec++; if (route_config !== 15'h7FF9) begin n_miss++; $display("FAIL single_route got %h want 7ff9", route_config); end
        n_vec++; if (deflect_count !== 16'd0) begin n_miss++; $display("FAIL single_count got %h want 0000", deflect_count); end
        n_vec++; if (inject_grant !== 1'b0) begin n_miss++; $display("FAIL single_inject got %b want 0", inject_grant); end
    endtask

    task automatic test_contention();
        set_in(13'h10DA, 13'h125A, 13'h0, 13'h0, 13'h0);
        step();
        n_vec++; if (route_config !== 15'h7FC8) begin n_miss++; $display("FAIL contend_route got %h want 7fc8", route_config); end
        n_vec++; if (deflect_count !== 16'd1) begin n_miss++; $display("FAIL contend_count got %h want 0001", deflect_count); end
    endtask

    task automatic test_eject();
        set_in(13'h0, 13'h0, 13'h1052, 13'h0, 13'h0);
        step();
        n_vec++; if (route_config !== 15'h7F3F) begin n_miss++; $display("FAIL eject_route got %h want 7f3f", route_config); end
        n_vec++; if (eject_valid !== 1'b1) begin n_miss++; $display("FAIL eject_valid got %b want 1", eject_valid); end
        n_vec++; if (deflect_count !== 16'd1) begin n_miss++; $display("FAIL eject_count got %h want 0001", deflect_count); end
    endtask

    task automatic test_injection();
        set_in(13'h1040, 13'h1080, 13'h10C0, 13'h1100, 13'h1000);
        step();
        n_vec++; if (route_config !== 15'h7681) begin n_miss++; $display("FAIL inj_block_route got %h want 7681", route_config); end
        n_vec++; if (inject_grant !== 1'b0) begin n_miss++; $display("FAIL inj_block_grant got %b want 0", inject_grant); end
        n_vec++; if (deflect_count !== 16'd3) begin n_miss++; $display("FAIL inj_block_count got %h want 0003", deflect_count); end
        set_in(13'h1040, 13'h1080, 13'h10C0, 13'h0, 13'h1000);
        step();
        n_vec++; if (route_config !== 15'h1ED0) begin n_miss++; $display("FAIL inj_ok_route got %h want 1ed0", route_config); end
        n_vec++; if (inject_grant !== 1'b1) begin n_miss++; $display("FAIL inj_ok_grant got %b want 1", inject_grant); end
        n_vec++; if (deflect_count !== 16'd5) begin n_miss++; $display("FAIL inj_ok_count got %h want 0005", deflect_count); end
        n_vec++; if (eject_valid !== 1'b0) begin n_miss++; $display("FAIL inj_ok_eject got %b want 0", eject_valid); end
    endtask

    task automatic test_back_to_back();
        set_in(13'h0, 13'h0, 13'h0, 13'h0, 13'h1012);
        step();
        n_vec++; if (route_config !== 15'h4FFF) begin n_miss++; $display("FAIL b2b_local_route got %h want 4fff", route_config); end
        n_vec++; if (inject_grant !== 1'b1) begin n_miss++; $display("FAIL b2b_local_grant got %b want 1", inject_grant); end
        n_vec++; if (eject_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_local_eject got %b want 1", eject_valid); end
        set_in(13'h0, 13'h0, 13'h0, 13'h0, 13'h0);
        step();
        n_vec++; if (route_config !== 15'h7FFF) begin n_miss++; $display("FAIL b2b_idle_route got %h want 7fff", route_config); end
        n_vec++; if (inject_grant !== 1'b0) begin n_miss++; $display("FAIL b2b_idle_grant got %b want 0", inject_grant); end
        set_in(13'h0, 13'h0, 13'h0, 13'h1002, 13'h1002);
        step();
        n_vec++; if (route_config !== 15'h07FF) begin n_miss++; $display("FAIL b2b_defl_route got %h want 07ff", route_config); end
        n_vec++; if (deflect_count !== 16'd6) begin n_miss++; $display("FAIL b2b_defl_count got %h want 0006", deflect_count); end
    endtask

    task automatic test_counter();
        // Four arrived flits: one ejects, three deflect.
        set_in(13'h1012, 13'h1012, 13'h1012, 13'h1012, 13'h0);
        count_clear = 1'b1;
        step();
        n_vec++; if (deflect_count !== 16'd0) begin n_miss++; $display("FAIL cnt_clear_prio got %h want 0000", deflect_count); end
        n_vec++; if (eject_valid !== 1'b1) begin n_miss++; $display("FAIL cnt_eject got %b want 1", eject_valid); end
        count_clear = 1'b0;
        repeat (21844) @(posedge clk);
        #1;
        n_vec++; if (deflect_count !== 16'hFFFC) begin n_miss++; $display("FAIL cnt_preload got %h want fffc", deflect_count); end
        set_in(13'h1040, 13'h1080, 13'h10C0, 13'h1100, 13'h1000);
        step();
        n_vec++; if (deflect_count !== 16'hFFFE) begin n_miss++; $display("FAIL cnt_near got %h want fffe", deflect_count); end
        set_in(13'h1012, 13'h1012, 13'h1012, 13'h1012, 13'h0);
        step();
        n_vec++; if (deflect_count !== 16'hFFFF) begin n_miss++; $display("FAIL cnt_sat got %h want ffff", deflect_count); end
        step();
        n_vec++; if (deflect_count !== 16'hFFFF) begin n_miss++; $display("FAIL cnt_hold got %h want ffff", deflect_count); end
        count_clear = 1'b1;
        step();
        n_vec++; if (deflect_count !== 16'd0) begin n_miss++; $display("FAIL cnt_clear_sat got %h want 0000", deflect_count); end
        count_clear = 1'b0;
    endtask

    task automatic test_reset_midstream();
        set_in(13'h115A, 13'h0, 13'h0, 13'h0, 13'h0);
        rst = 1'b1;
        step();
        n_vec++; if (route_config !== 15'h7FFF) begin n_miss++; $display("FAIL mid_rst_route got %h want 7fff", route_config); end
        rst = 1'b0;
        step();
        n_vec++; if (route_config !== 15'h7FF9) begin n_miss++; $display("FAIL mid_rst_fresh got %h want 7ff9", route_config); end
    endtask

    task automatic test_tie();
        logic [14:0] exp_route [3];
`ifdef BLESS_RR_TIE_EN
        exp_route[0] = 15'h7FC1; exp_route[1] = 15'h7FC8; exp_route[2] = 15'h7FC1;
`else
        exp_route[0] = 15'h7FC1; exp_route[1] = 15'h7FC1; exp_route[2] = 15'h7FC1;
`endif
        rst = 1'b1;
        set_in(13'h0, 13'h0, 13'h0, 13'h0, 13'h0);
        step(); step();
        rst = 1'b0;
        set_in(13'h101A, 13'h101A, 13'h0, 13'h0, 13'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (route_config !== exp_route[k]) begin
                n_miss++; $display("FAIL tie_cycle%0d got %h want %h", k, route_config, exp_route[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_flit();
        test_contention();
        test_eject();
        test_injection();
        test_back_to_back();
        test_counter();
        test_reset_midstream();
        test_tie();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bless_age_allocator.md
Name: bless_age_allocator

Overview:
- Age-based BLESS output-port allocator for the 5-port bufferless router.
- Generates the 15-bit route_config that drives the crossbar select; it is the producing end of the route_config interface.
- Samples the five 13-bit flit control words, ranks valid flits oldest-first and grants each one output: productive, deflected, ejected, or none.
- Registers the result so route_config is valid one cycle after sampling. Also produces injection grant and deflection statistics.

Parameters:
MY_X, 2, router X coordinate (3 bits)
MY_Y, 2, router Y coordinate (3 bits)
CNT_W, 16, deflection counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
control0_in..control3_in  input  13 each  network input flit control (0=N,1=E,2=S,3=W)
control4_in  input  13  local injection flit control
count_clear  input  1  synchronous clear of deflect_count
route_config  output  15  [3i+2:3i] = output port for input i; 3'b111 = no route
inject_grant  output  1  local flit (input 4) allocated this cycle
eject_valid  output  1  some flit routed to output 4 (local)
deflect_count  output  CNT_W  saturating count of deflected flits

Behaviour:
- Control word: [12] valid, [11:6] age (unsigned, larger = older), [5:3] dest_x, [2:0] dest_y.
- Port codes: 0=N, 1=E, 2=S, 3=W, 4=Local; codes 5-7 never issued except 111 = unrouted.
- Productive ports:
  - dest_x>MY_X -> E; dest_x<MY_X -> W.
  - Y direction: dest_y>MY_Y -> N; dest_y<MY_Y -> S.
  - Preferred port is X if X differs, else Y. Secondary port is Y when both X and Y differ.
  - dest == (MY_X,MY_Y) -> preferred Local, no secondary.
- Ranking: valid flits only, descending age. Tie broken by lower input index (default) or the optional rotating pointer.
- Allocation, greedy in rank order, each output used at most once:
  - Network inputs 0-3:
    1. Preferred port if free.
    2. Else secondary port if free.
    3. Else lowest-numbered free port among 0-3 (deflection).
  - Arrived flits that lose Local deflect to the lowest free port in 0-3.
  - Network inputs 0-3 are always granted; at most 4 such flits exist and a non-arrived flit never takes Local.
  - Input 4: granted only if its chosen port is still free after ranking, where the chosen port is Local if arrived, else preferred -> secondary -> lowest free in 0-3. Otherwise field 4 = 111 and inject_grant = 0.
- Invalid inputs: field = 111.
- Timing: inputs sampled at posedge n; route_config, inject_grant and eject_valid are registered and reflect that sample from posedge n+1. Latency is 1 cycle; output is a new allocation every cycle.
- deflect_count: += number of flits granted a port that is neither preferred nor secondary, applied at the same edge as route_config. Saturates at all-ones. count_clear forces 0 and takes priority over increment.
- Reset: route_config = 15'h7FFF, inject_grant = 0, eject_valid = 0, deflect_count = 0, rr pointer = 0. Reset mid-stream discards the in-flight allocation; the first cycle after rst deasserts samples fresh inputs.

Optional Feature:
- Macro BLESS_RR_TIE_EN.
- Defined: ties among equal ages resolve by a 3-bit rotating pointer. The input index equal to the pointer wins, then increasing index mod 5. The pointer advances by 1 (mod 5) on every cycle in which at least one valid flit is sampled; it is reset to 0.
- Undefined: fixed lower-index-wins, no pointer register.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs 13'h1FFF -> route_config=15'h7FFF, inject_grant=0, eject_valid=0, deflect_count=0.
- Single flit: control0_in=13'h115A (age 5, dest 3,2), others 0 -> next cycle route_config=15'h7FF9 (in0->E); deflect_count stays 0.
- Contention: control0_in=13'h10DA (age 3), control1_in=13'h125A (age 9), both dest (3,2) -> route_config=15'h7FC8 (in1->E, in0 deflected to N); deflect_count=1.
- Eject: control2_in=13'h1052 (dest 2,2), others 0 -> route_config=15'h7F3F; eject_valid=1.
- Injection blocked: inputs 0-3 valid with dest (0,0) and ages 1-4; input 4 valid -> field4=111, inject_grant=0, all of outputs 0-3 used, deflect_count += 2. Same cycle with only inputs 0-2 valid -> inject_grant=1.
- Counter: preload near saturation by repeated contention -> count holds at 16'hFFFF; count_clear asserted concurrently with a deflection -> 0. With BLESS_RR_TIE_EN, two equal-age flits to the same port alternate the winner on consecutive cycles.
